buffer_drain_dma: RTL and testbench
===================================

Name: buffer_drain_dma

Overview:
Downstream consumer of the flash acquisition buffer. When the acquisition block raises Interrupt_en, this block reads every entry of both buffer banks (buffermem 1/2) and copies them into system RAM through a req/ack write port. It alternates between two RAM frames. When the copy is complete, it issues the IO acknowledge write (Write_IO with Adress_bus = 0x5001) itself, so the CPU no longer services each interrupt.

Parameters:
BUF_DEPTH, 16, entries per buffer bank; must be a power of 2, at least 2.
DATA_W, 16, sample width.
ADDR_W, 16, system address width.
DEST_BASE, 16'h6000, RAM base of frame 0. Frame 1 starts at DEST_BASE + 2*BUF_DEPTH.
ACK_ADDR, 16'h5001, IO address used for the acknowledge write.
CLR_TIMEOUT, 255, maximum cycles to wait for Interrupt_en to drop after the acknowledge.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
Interrupt_en  in  1  level from the acquisition block; high means the buffers are full.
buf_rd_en  out  1  read strobe to both buffer banks.
buf_rd_addr  out  log2(BUF_DEPTH)  buffer entry index.
buf_rd_data1  in  DATA_W  bank-1 read data; valid 1 cycle after buf_rd_en.
buf_rd_data2  in  DATA_W  bank-2 read data; valid 1 cycle after buf_rd_en.
mem_req  out  1  RAM write request.
mem_addr  out  ADDR_W  RAM write address.
mem_wdata  out  DATA_W  RAM write data.
mem_ack  in  1  RAM write accepted (sampled on a clock edge).
Write_IO  out  1  IO write strobe.
Adress_bus  out  ADDR_W  IO address.
busy  out  1  high in every state except IDLE.
frame_sel  out  1  RAM frame used by the current or next transfer.
frame_count  out  8  completed transfers; wraps at 255 -> 0.
ack_timeout  out  1  sticky error flag.

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, index 0, frame_sel 0, timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, RD, WAIT, WR1, WR2, ACK, CLR.
  - IDLE: if Interrupt_en=1 on a clock edge -> RD with index 0.
  - RD: buf_rd_en=1 for 1 cycle, buf_rd_addr=index -> WAIT.
  - WAIT: capture buf_rd_data1/2 into holding registers at the end of the cycle -> WR1.
  - WR1: mem_req=1, mem_addr = frame base + 2*index, mem_wdata = data1. Hold all three stable until mem_ack=1 is sampled, then -> WR2. An ack in the first cycle of the request is legal (zero wait).
  - WR2: same handshake, with mem_addr = frame base + 2*index + 1 and mem_wdata = data2. On ack: if index = BUF_DEPTH-1 -> ACK; otherwise index+1 -> RD.
  - ACK: Write_IO=1 and Adress_bus=ACK_ADDR for exactly 1 cycle. On leaving ACK: toggle frame_sel, increment frame_count -> CLR.
  - CLR: Write_IO=0, Adress_bus=0. Wait for Interrupt_en=0, then -> IDLE and clear the timeout counter.
  - CLR timeout: if Interrupt_en is still 1 after CLR_TIMEOUT cycles, set ack_timeout (sticky, cleared only by reset) and go to IDLE. A new transfer then starts and re-reads the buffers.
- mem_ack sampled outside WR1/WR2 is ignored.
- Adress_bus is 0 whenever Write_IO=0.
- Timing with a zero-wait RAM:
  - Each entry pair takes 4 cycles.
  - Write_IO rises 4*BUF_DEPTH+1 cycles after the IDLE edge that sampled Interrupt_en=1 (65 cycles for depth 16).
- Interrupt_en dropping mid-transfer: ignored; the transfer completes and the acknowledge is still issued.
- Reset mid-transfer: the transfer is aborted with no acknowledge. If Interrupt_en is still high after reset, the copy restarts at index 0 into frame 0.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.

Decomposition:
- Shared package holds:
  - FSM state encoding;
  - the IO address constants 16'h5000 (start) and 16'h5001 (ack);
  - DEST_BASE default.
- One natural sub-module, mem_write_port: the req/ack handshake holder for addr/data. WR1 and WR2 both use it.

Test Plan:
- Zero-wait RAM (mem_ack tied 1), BUF_DEPTH=16, bank data = index and index+16'h100, Interrupt_en raised -> RAM 0x6000..0x601F holds 0,0x100,1,0x101,...; Write_IO high 1 cycle at cycle 65 with Adress_bus=0x5001; frame_sel=1; frame_count=1.
- Random 0-3 cycle mem_ack delays -> mem_addr/mem_wdata stable while mem_req=1 and unacked; RAM contents identical to the first test.
- Second interrupt after Interrupt_en drops -> writes land at 0x6020..0x603F; frame_sel returns to 0; frame_count=2.
- Interrupt_en held high after the ack -> ack_timeout=1 exactly CLR_TIMEOUT cycles after entering CLR; a new transfer starts; the flag stays 1 until reset.
- reset=0 asserted mid-WR1 at index 5 -> all outputs 0 immediately (async); after release with Interrupt_en high, the copy restarts at 0x6000, index 0.
- Interrupt_en dropped at index 3 -> transfer completes all 16 entries and Write_IO still pulses once; block returns to IDLE.

Source files
------------

// File: rtl/buffer_drain_dma_pkg.sv
// rtl/buffer_drain_dma_pkg.sv - shared state encoding and address constants for the buffer drain DMA
package buffer_drain_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR1,
    S_WR2,
    S_ACK,
    S_CLR
  } state_t;

  localparam logic [15:0] IO_START_ADDR     = 16'h5000;
  localparam logic [15:0] IO_ACK_ADDR       = 16'h5001;
  localparam logic [15:0] DEST_BASE_DEFAULT = 16'h6000;

endpackage

// File: rtl/buffer_drain_dma_mem_write_port.sv
// rtl/buffer_drain_dma_mem_write_port.sv - req/ack write holder; addr/data stay frozen until the ack is sampled
module buffer_drain_dma_mem_write_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done
);

  // Ack only counts while a request is outstanding.
  assign done = mem_req & mem_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_req   <= 1'b1;
      mem_addr  <= load_addr;
      mem_wdata <= load_data;
    end else if (done) begin
      mem_req <= 1'b0;
    end
  end

endmodule

// File: rtl/buffer_drain_dma.sv
// rtl/buffer_drain_dma.sv - copies both acquisition buffer banks into alternating RAM frames, then writes the IO acknowledge
module buffer_drain_dma
  import buffer_drain_dma_pkg::*;
#(
  parameter int                BUF_DEPTH   = 16,
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] DEST_BASE   = ADDR_W'(DEST_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] ACK_ADDR    = ADDR_W'(IO_ACK_ADDR),
  parameter int                CLR_TIMEOUT = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         Interrupt_en,
  output logic                         buf_rd_en,
  output logic [$clog2(BUF_DEPTH)-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0]            buf_rd_data1,
  input  logic [DATA_W-1:0]            buf_rd_data2,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  output logic                         Write_IO,
  output logic [ADDR_W-1:0]            Adress_bus,
  output logic                         busy,
  output logic                         frame_sel,
  output logic [7:0]                   frame_count,
  output logic                         ack_timeout
);

  localparam int IW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(CLR_TIMEOUT + 1);
  localparam logic [IW-1:0]     LAST_IDX    = IW'(BUF_DEPTH - 1);
  localparam logic [TW-1:0]     TMO_LAST    = TW'(CLR_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] FRAME1_BASE = DEST_BASE + ADDR_W'(2 * BUF_DEPTH);

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next;
  logic [DATA_W-1:0]   hold2;
  logic [TW-1:0]       tmo, tmo_next;
  logic                rd_en_next, wio_next, frame_sel_next, timeout_next;
  logic [ADDR_W-1:0]   abus_next, frame_base, load_addr;
  logic [DATA_W-1:0]   load_data;
  logic [7:0]          count_next;
  logic                load, done;

  assign frame_base = frame_sel ? FRAME1_BASE : DEST_BASE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      hold2       <= '0;
      tmo         <= '0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      Write_IO    <= 1'b0;
      Adress_bus  <= '0;
      busy        <= 1'b0;
      frame_sel   <= 1'b0;
      frame_count <= '0;
      ack_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      tmo         <= tmo_next;
      buf_rd_en   <= rd_en_next;
      buf_rd_addr <= idx_next;
      Write_IO    <= wio_next;
      Adress_bus  <= abus_next;
      busy        <= (state_next != S_IDLE);
      frame_sel   <= frame_sel_next;
      frame_count <= count_next;
      ack_timeout <= timeout_next;
      // Bank-2 sample is parked here while bank-1 goes out in WR1.
      if (state == S_WAIT) hold2 <= buf_rd_data2;
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    rd_en_next     = 1'b0;
    wio_next       = 1'b0;
    abus_next      = '0;
    load           = 1'b0;
    load_addr      = frame_base + ADDR_W'({idx, 1'b0});
    load_data      = buf_rd_data1;
    tmo_next       = tmo;
    frame_sel_next = frame_sel;
    count_next     = frame_count;
    timeout_next   = ack_timeout;
    unique case (state)
      S_IDLE: if (Interrupt_en) begin
        state_next = S_RD;
        idx_next   = '0;
        rd_en_next = 1'b1;
        tmo_next   = '0;
      end
      S_RD:   state_next = S_WAIT;
      S_WAIT: begin
        state_next = S_WR1;
        load       = 1'b1;
      end
      S_WR1: if (done) begin
        state_next = S_WR2;
        load       = 1'b1;
        load_addr  = frame_base + ADDR_W'({idx, 1'b1});
        load_data  = hold2;
      end
      S_WR2: if (done) begin
        if (idx == LAST_IDX) begin
          state_next = S_ACK;
          wio_next   = 1'b1;
          abus_next  = ACK_ADDR;
        end else begin
          state_next = S_RD;
          idx_next   = idx + 1'b1;
          rd_en_next = 1'b1;
        end
      end
      S_ACK: begin
        state_next     = S_CLR;
        frame_sel_next = ~frame_sel;
        count_next     = frame_count + 8'd1;
        tmo_next       = '0;
      end
      S_CLR: begin
        // A stuck interrupt line forces a fresh copy rather than a hang.
        if (!Interrupt_en) begin
          state_next = S_IDLE;
          tmo_next   = '0;
        end else if (tmo == TMO_LAST) begin
          state_next   = S_IDLE;
          timeout_next = 1'b1;
          tmo_next     = '0;
        end else begin
          tmo_next = tmo + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  buffer_drain_dma_mem_write_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_write_port (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done)
  );

endmodule

// File: tb/tb_buffer_drain_dma.sv
// tb/tb_buffer_drain_dma.sv - self-checking bench for buffer_drain_dma with a RAM/buffer reference model
module tb_buffer_drain_dma;

  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'h6000;
  localparam logic [15:0] ACKA  = 16'h5001;
  localparam int          TMO   = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        Interrupt_en;
  logic        buf_rd_en;
  logic [3:0]  buf_rd_addr;
  logic [15:0] buf_rd_data1 = '0;
  logic [15:0] buf_rd_data2 = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b1;
  logic        Write_IO;
  logic [15:0] Adress_bus;
  logic        busy;
  logic        frame_sel;
  logic [7:0]  frame_count;
  logic        ack_timeout;

  buffer_drain_dma dut (
    .clock        (clock),
    .reset        (reset),
    .Interrupt_en (Interrupt_en),
    .buf_rd_en    (buf_rd_en),
    .buf_rd_addr  (buf_rd_addr),
    .buf_rd_data1 (buf_rd_data1),
    .buf_rd_data2 (buf_rd_data2),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .Write_IO     (Write_IO),
    .Adress_bus   (Adress_bus),
    .busy         (busy),
    .frame_sel    (frame_sel),
    .frame_count  (frame_count),
    .ack_timeout  (ack_timeout)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] bank1 [DEPTH];
  logic [15:0] bank2 [DEPTH];
  logic [31:0] wlog [$];
  int          wio_cyc [$];
  int          wio_count = 0;
  int          bad_abus = 0;
  int          stable_err = 0;
  bit          ack_mode = 1'b0;
  int          wait_left = 0;
  bit          p_pending = 1'b0;
  logic [15:0] p_addr = '0;
  logic [15:0] p_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (buf_rd_en) begin
      buf_rd_data1 <= bank1[buf_rd_addr];
      buf_rd_data2 <= bank2[buf_rd_addr];
    end
  end

  // RAM responder and protocol monitor; ack decided here is sampled at the next rising edge.
  always @(negedge clock) begin
    if (p_pending && !(mem_req && mem_addr == p_addr && mem_wdata == p_data))
      stable_err <= stable_err + 1;
    if (mem_req) begin
      if (!ack_mode || wait_left == 0) begin
        mem_ack   <= 1'b1;
        wlog.push_back({mem_addr, mem_wdata});
        wait_left <= int'($urandom_range(0, 3));
        p_pending <= 1'b0;
      end else begin
        mem_ack   <= 1'b0;
        wait_left <= wait_left - 1;
        p_pending <= 1'b1;
        p_addr    <= mem_addr;
        p_data    <= mem_wdata;
      end
    end else begin
      mem_ack   <= ack_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      p_pending <= 1'b0;
    end
    if (Write_IO) begin
      wio_count <= wio_count + 1;
      wio_cyc.push_back(cyc);
      if (Adress_bus !== ACKA) bad_abus <= bad_abus + 1;
    end else if (Adress_bus !== 16'h0) begin
      bad_abus <= bad_abus + 1;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: entry i of a frame lands at base + 2i (bank 1) and base + 2i + 1 (bank 2).
  task automatic check_copy(input string tag, input int start, input int frame);
    int          bad = 0;
    logic [15:0] ea;
    logic [31:0] e;
    check({tag, "_count"}, wlog.size() - start, 2 * DEPTH);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      ea = BASE + 16'(frame * 2 * DEPTH + i);
      e  = {ea, (i % 2 == 0) ? bank1[i / 2] : bank2[i / 2]};
      if (start + i >= wlog.size() || wlog[start + i] !== e) bad++;
    end
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic wait_pulse(input int n0, input string tag);
    int t = 0;
    while (wio_count <= n0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_pulse_seen"}, longint'(wio_count > n0), 1);
  endtask

  task automatic wait_write(input logic [15:0] addr, input string tag);
    int t = 0;
    while (!(mem_req && mem_addr == addr) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_reached"}, longint'(mem_req && mem_addr == addr), 1);
  endtask

  initial begin
    int n0, s0, s1, k, w, t;
    int exp_frame, exp_count;
    reset        = 1'b0;
    Interrupt_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bank1[i] = 16'(i);
      bank2[i] = 16'(i) + 16'h0100;
    end
    exp_frame = 0;
    exp_count = 0;
    repeat (2) @(negedge clock);
    check("reset_bus_outputs", {mem_addr, mem_wdata, Adress_bus}, 0);
    check("reset_ctrl_outputs", {buf_rd_en, buf_rd_addr, mem_req, Write_IO, busy,
                                 frame_sel, frame_count, ack_timeout}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Zero-wait copy into frame 0 with acknowledge timing.
    n0 = wio_count; s0 = wlog.size(); k = cyc;
    Interrupt_en = 1'b1;
    wait_pulse(n0, "t1");
    check("t1_ack_cycle", wio_cyc[n0] - k, 4 * DEPTH + 1);
    Interrupt_en = 1'b0;
    repeat (4) @(negedge clock);
    exp_frame = 1; exp_count = 1;
    check("t1_pulse_count", wio_count - n0, 1);
    check_copy("t1_copy", s0, 0);
    check("t1_frame_sel", frame_sel, exp_frame);
    check("t1_frame_count", frame_count, exp_count);
    check("t1_idle", busy, 0);

    // Second interrupt with random RAM wait states lands in frame 1.
    ack_mode = 1'b1;
    n0 = wio_count; s0 = wlog.size();
    Interrupt_en = 1'b1;
    wait_pulse(n0, "t2");
    Interrupt_en = 1'b0;
    repeat (4) @(negedge clock);
    check_copy("t2_copy", s0, exp_frame);
    exp_frame = 0; exp_count = 2;
    check("t2_frame_sel", frame_sel, exp_frame);
    check("t2_frame_count", frame_count, exp_count);

    // Random sample data, random wait states.
    for (int i = 0; i < DEPTH; i++) begin
      bank1[i] = 16'($urandom);
      bank2[i] = 16'($urandom);
    end
    n0 = wio_count; s0 = wlog.size();
    Interrupt_en = 1'b1;
    wait_pulse(n0, "t3");
    Interrupt_en = 1'b0;
    repeat (4) @(negedge clock);
    check_copy("t3_copy", s0, exp_frame);
    exp_frame = 1; exp_count = 3;
    check("t3_frame_count", frame_count, exp_count);

    // Interrupt held high: timeout after CLR_TIMEOUT cycles in CLR, then a fresh copy.
    n0 = wio_count; s0 = wlog.size();
    Interrupt_en = 1'b1;
    wait_pulse(n0, "t4a");
    w = wio_cyc[n0];
    t = 0;
    while (cyc < w + TMO && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check("t4_flag_before", ack_timeout, 0);
    @(negedge clock);
    check("t4_flag_at_timeout", ack_timeout, 1);
    check_copy("t4_first_copy", s0, exp_frame);
    exp_frame = 0; exp_count = 4;
    s1 = wlog.size();
    wait_pulse(n0 + 1, "t4b");
    Interrupt_en = 1'b0;
    repeat (4) @(negedge clock);
    check_copy("t4_retransfer", s1, exp_frame);
    exp_frame = 1; exp_count = 5;
    check("t4_frame_count", frame_count, exp_count);
    check("t4_flag_sticky", ack_timeout, 1);
    check("handshake_stable", stable_err, 0);

    // Asynchronous reset during WR1 of index 5 aborts; copy restarts at frame 0, index 0.
    ack_mode = 1'b0;
    repeat (2) @(negedge clock);
    n0 = wio_count;
    Interrupt_en = 1'b1;
    wait_write(BASE + 16'(exp_frame * 2 * DEPTH + 10), "t5_idx5");
    reset = 1'b0;
    #1;
    check("t5_async_bus_outputs", {mem_addr, mem_wdata, Adress_bus}, 0);
    check("t5_async_ctrl_outputs", {buf_rd_en, buf_rd_addr, mem_req, Write_IO, busy,
                                    frame_sel, frame_count, ack_timeout}, 0);
    check("t5_no_ack_on_abort", wio_count - n0, 0);
    @(negedge clock);
    s0 = wlog.size();
    reset = 1'b1;
    exp_frame = 0; exp_count = 0;
    wait_pulse(n0, "t5");
    Interrupt_en = 1'b0;
    repeat (4) @(negedge clock);
    check_copy("t5_restart_copy", s0, exp_frame);
    exp_frame = 1; exp_count = 1;
    check("t5_frame_sel", frame_sel, exp_frame);
    check("t5_frame_count", frame_count, exp_count);

    // Interrupt dropped at index 3: copy still completes with a single acknowledge.
    n0 = wio_count; s0 = wlog.size();
    Interrupt_en = 1'b1;
    wait_write(BASE + 16'(exp_frame * 2 * DEPTH + 6), "t6_idx3");
    Interrupt_en = 1'b0;
    wait_pulse(n0, "t6");
    repeat (4) @(negedge clock);
    check("t6_pulse_count", wio_count - n0, 1);
    check_copy("t6_copy", s0, exp_frame);
    exp_frame = 0; exp_count = 2;
    check("t6_frame_sel", frame_sel, exp_frame);
    check("t6_frame_count", frame_count, exp_count);
    check("t6_idle", busy, 0);
    check("adress_bus_rule", bad_abus, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
